// File: rtl/mole_pkg.sv
// Shared types and helpers for the whack-a-mole round engine.
// Contents: round state enum, default LFSR tap mask, clog2 helper.
package mole_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PICK,
        SHOW,
        GAP,
        DONE
    } state_t;

    // x^6 + x^5 + 1, maximal length for a 6-bit register
    localparam logic [5:0] TAPS_DEFAULT = 6'b110000;

    // Ceiling log2, never less than 1 so it can size a vector directly
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned width;
        width = 1;
        while ((32'd1 << width) < value) begin
            width++;
        end
        return width;
    endfunction

endpackage

// File: rtl/mole_sched_if.sv
// Player/display-side bundle of the mole round engine.
// master: drives start, seed, hold length and buttons; observes the game outputs.
// slave : the engine itself.
interface mole_sched_if #(
    parameter int unsigned LFSR_W  = 6,
    parameter int unsigned N_HOLES = 8,
    parameter int unsigned HOLD_W  = 24,
    parameter int unsigned SCORE_W = 6
);

    logic                i_start;
    logic                i_seed_dv;
    logic [LFSR_W-1:0]   i_seed_data;
    logic [HOLD_W-1:0]   i_hold_len;
    logic [N_HOLES-1:0]  button;

    logic [N_HOLES-1:0]  o_mole;
    logic [SCORE_W-1:0]  o_score;
    logic [SCORE_W-1:0]  o_miss;
    logic                o_hit;
    logic                o_busy;
    logic                o_done;
    logic [LFSR_W-1:0]   o_rand;

    modport master (
        output i_start, i_seed_dv, i_seed_data, i_hold_len, button,
        input  o_mole, o_score, o_miss, o_hit, o_busy, o_done, o_rand
    );

    modport slave (
        input  i_start, i_seed_dv, i_seed_data, i_hold_len, button,
        output o_mole, o_score, o_miss, o_hit, o_busy, o_done, o_rand
    );

endinterface

// File: rtl/lfsr_core.sv
// Seedable Fibonacci LFSR, steps every cycle.
// Ports: clk, reset (async active-low), seed_dv/seed_data (load, zero seed loads 1),
//        q (current state, never 0).
module lfsr_core
    import mole_pkg::*;
#(
    parameter int unsigned       LFSR_W = 6,
    parameter logic [LFSR_W-1:0] TAPS   = LFSR_W'(TAPS_DEFAULT)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              seed_dv,
    input  logic [LFSR_W-1:0] seed_data,
    output logic [LFSR_W-1:0] q
);

    logic fb;

    assign fb = ^(q & TAPS);

    // Seed load wins over stepping; a zero seed would lock the register up
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q <= LFSR_W'(1);
        end else if (seed_dv) begin
            q <= (seed_data == '0) ? LFSR_W'(1) : seed_data;
        end else begin
            q <= {q[LFSR_W-2:0], fb};
        end
    end

endmodule

// File: rtl/mole_sched.sv
// Whack-a-mole round engine: picks a random hole, lights it for a hold time,
// scores presses against it and runs a fixed number of rounds per game.
// Ports: clk, reset (async active-low), bus (mole_sched_if.slave: start, seed,
//        hold length, buttons in; mole, score, miss, hit, busy, done, rand out).
// Build option: define SPEEDUP_EN to shorten the hold time by 1/8 on every hit,
//               floored at MIN_HOLD.
module mole_sched
    import mole_pkg::*;
#(
    parameter int unsigned       LFSR_W     = 6,
    parameter logic [LFSR_W-1:0] TAPS       = LFSR_W'(TAPS_DEFAULT),
    parameter int unsigned       N_HOLES    = 8,
    parameter int unsigned       HOLD_W     = 24,
    parameter int unsigned       GAP_CYCLES = 4,
    parameter int unsigned       ROUNDS     = 32,
    parameter int unsigned       SCORE_W    = 6,
    parameter int unsigned       MIN_HOLD   = 16
) (
    input logic         clk,
    input logic         reset,
    mole_sched_if.slave bus
);

    localparam int unsigned IDX_W = clog2(N_HOLES);
    localparam int unsigned RND_W = clog2(ROUNDS + 1);
    localparam int unsigned GAP_W = clog2(GAP_CYCLES);

    state_t             state, state_n;
    logic [LFSR_W-1:0]  lfsr;
    logic [N_HOLES-1:0] button_q, press;
    logic [N_HOLES-1:0] mole, mole_n;
    logic [SCORE_W-1:0] score, score_n;
    logic [SCORE_W-1:0] miss, miss_n;
    logic               hit, hit_n;
    logic               busy, busy_n;
    logic               done, done_n;
    logic [HOLD_W-1:0]  timer, timer_n;
    logic [HOLD_W-1:0]  hold_cur;
    logic [RND_W-1:0]   round, round_n;
    logic [GAP_W-1:0]   gap_cnt, gap_cnt_n;
    logic [IDX_W-1:0]   idx, prev, prev_n;
    logic               prev_valid, prev_valid_n;
    logic               cand_ok, hit_now, wrong_now, timeout;

    function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v);
        return (v == '1) ? v : v + SCORE_W'(1);
    endfunction

    lfsr_core #(
        .LFSR_W (LFSR_W),
        .TAPS   (TAPS)
    ) u_lfsr (
        .clk       (clk),
        .reset     (reset),
        .seed_dv   (bus.i_seed_dv),
        .seed_data (bus.i_seed_data),
        .q         (lfsr)
    );

    // Candidate hole from the low LFSR bits; never repeat the previous hole
    assign idx       = lfsr[IDX_W-1:0];
    assign cand_ok   = (32'(idx) < N_HOLES) && (!prev_valid || (idx != prev));
    assign press     = bus.button & ~button_q;
    assign hit_now   = |(press & mole);
    assign wrong_now = (|press) && !hit_now;
    assign timeout   = (timer == HOLD_W'(1));

`ifdef SPEEDUP_EN
    logic [HOLD_W-1:0] hold, hold_n, hold_dec;

    assign hold_dec = hold - (hold >> 3);
    assign hold_cur = hold;

    // Per-game hold length, shrinks on each hit
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hold <= '0;
        end else begin
            hold <= hold_n;
        end
    end
`else
    // The hold floor only matters when the speed-up is built in
    localparam int unsigned min_hold_unused = MIN_HOLD;

    assign hold_cur = bus.i_hold_len;
`endif

    // Round FSM: next state, counters and next registered outputs
    always_comb begin
        state_n      = state;
        mole_n       = mole;
        score_n      = score;
        miss_n       = miss;
        hit_n        = 1'b0;
        timer_n      = timer;
        round_n      = round;
        gap_cnt_n    = gap_cnt;
        prev_n       = prev;
        prev_valid_n = prev_valid;
`ifdef SPEEDUP_EN
        hold_n       = hold;
`endif
        case (state)
            IDLE, DONE: begin
                mole_n = '0;
                if (bus.i_start) begin
                    score_n      = '0;
                    miss_n       = '0;
                    round_n      = '0;
                    prev_valid_n = 1'b0;
`ifdef SPEEDUP_EN
                    hold_n       = bus.i_hold_len;
`endif
                    state_n      = PICK;
                end
            end
            PICK: begin
                mole_n = '0;
                if (cand_ok) begin
                    mole_n       = N_HOLES'(1) << idx;
                    prev_n       = idx;
                    prev_valid_n = 1'b1;
                    timer_n      = (hold_cur == '0) ? HOLD_W'(1) : hold_cur;
                    state_n      = SHOW;
                end
            end
            SHOW: begin
                timer_n = timer - HOLD_W'(1);
                // A correct hit overrides both a simultaneous wrong press and the timeout
                if (hit_now) begin
                    hit_n     = 1'b1;
                    score_n   = sat_inc(score);
                    mole_n    = '0;
                    gap_cnt_n = '0;
                    state_n   = GAP;
`ifdef SPEEDUP_EN
                    hold_n    = (hold_dec < HOLD_W'(MIN_HOLD)) ? HOLD_W'(MIN_HOLD) : hold_dec;
`endif
                end else begin
                    if (wrong_now) begin
                        miss_n = sat_inc(miss_n);
                    end
                    if (timeout) begin
                        miss_n    = sat_inc(miss_n);
                        mole_n    = '0;
                        gap_cnt_n = '0;
                        state_n   = GAP;
                    end
                end
            end
            GAP: begin
                mole_n = '0;
                if (gap_cnt == GAP_W'(GAP_CYCLES - 1)) begin
                    round_n = round + RND_W'(1);
                    state_n = (round_n == RND_W'(ROUNDS)) ? DONE : PICK;
                end else begin
                    gap_cnt_n = gap_cnt + GAP_W'(1);
                end
            end
            default: begin
                mole_n  = '0;
                state_n = IDLE;
            end
        endcase
        busy_n = (state_n == PICK) || (state_n == SHOW) || (state_n == GAP);
        done_n = (state_n == DONE);
    end

    // State, counters, button edge history and output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            button_q   <= '0;
            mole       <= '0;
            score      <= '0;
            miss       <= '0;
            hit        <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            timer      <= '0;
            round      <= '0;
            gap_cnt    <= '0;
            prev       <= '0;
            prev_valid <= 1'b0;
        end else begin
            state      <= state_n;
            button_q   <= bus.button;
            mole       <= mole_n;
            score      <= score_n;
            miss       <= miss_n;
            hit        <= hit_n;
            busy       <= busy_n;
            done       <= done_n;
            timer      <= timer_n;
            round      <= round_n;
            gap_cnt    <= gap_cnt_n;
            prev       <= prev_n;
            prev_valid <= prev_valid_n;
        end
    end

    assign bus.o_mole  = mole;
    assign bus.o_score = score;
    assign bus.o_miss  = miss;
    assign bus.o_hit   = hit;
    assign bus.o_busy  = busy;
    assign bus.o_done  = done;
    assign bus.o_rand  = lfsr;

endmodule

// File: tb/tb_mole_sched.sv
// Self-checking bench for mole_sched: directed game scenarios plus random games,
// compared against a round-level behavioural model of the game rules.
module tb_mole_sched;

    localparam int unsigned LFSR_W     = 6;
    localparam int unsigned N_HOLES    = 8;
    localparam int unsigned HOLD_W     = 24;
    localparam int unsigned GAP_CYCLES = 4;
    localparam int unsigned ROUNDS     = 4;
    localparam int unsigned SCORE_W    = 6;
    localparam int unsigned MIN_HOLD   = 16;
    localparam int          TAPS       = 'h30;
    localparam int          LFSR_MOD   = 64;
    localparam int          IDX_MOD    = 8;
    localparam int          SCORE_MAX  = 63;
    localparam int          PICK_BOUND = 64;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    mole_sched_if #(
        .LFSR_W  (LFSR_W),
        .N_HOLES (N_HOLES),
        .HOLD_W  (HOLD_W),
        .SCORE_W (SCORE_W)
    ) bus ();

    mole_sched #(
        .LFSR_W     (LFSR_W),
        .TAPS       (6'b110000),
        .N_HOLES    (N_HOLES),
        .HOLD_W     (HOLD_W),
        .GAP_CYCLES (GAP_CYCLES),
        .ROUNDS     (ROUNDS),
        .SCORE_W    (SCORE_W),
        .MIN_HOLD   (MIN_HOLD)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int m_lfsr;
    int m_score;
    int m_miss;
    int m_prev;
    int m_hold;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int sat1(input int v);
        return (v >= SCORE_MAX) ? SCORE_MAX : v + 1;
    endfunction

    // Reference LFSR: shift left, feed back the parity of the tapped bits
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_lfsr <= 1;
        end else if (bus.i_seed_dv) begin
            m_lfsr <= (bus.i_seed_data == '0) ? 1 : int'(bus.i_seed_data);
        end else begin
            m_lfsr <= ((m_lfsr * 2) % LFSR_MOD) + ($countones(m_lfsr & TAPS) % 2);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_game(input int hold);
        bus.i_hold_len = HOLD_W'(hold);
        bus.i_start    = 1'b1;
        tick();
        bus.i_start = 1'b0;
        m_score = 0;
        m_miss  = 0;
        m_prev  = -1;
        m_hold  = hold;
        chk("start_busy", 32'(bus.o_busy), 1);
        chk("start_done", 32'(bus.o_done), 0);
        chk("start_score", 32'(bus.o_score), 0);
        chk("start_miss", 32'(bus.o_miss), 0);
        chk("start_mole", 32'(bus.o_mole), 0);
    endtask

    // Idle in PICK until the model LFSR offers a legal hole, then see it lit
    task automatic wait_pick(output int idx);
        int waited;
        waited = 0;
        while ((((m_lfsr % IDX_MOD) >= N_HOLES) || ((m_lfsr % IDX_MOD) == m_prev))
               && (waited < PICK_BOUND)) begin
            chk("pick_dark", 32'(bus.o_mole), 0);
            tick();
            waited++;
        end
        chk("pick_bound", 32'(waited < PICK_BOUND), 1);
        idx = m_lfsr % IDX_MOD;
        tick();
        chk("mole_lit", 32'(bus.o_mole), 32'(1) << idx);
        chk("rand_track", 32'(bus.o_rand), m_lfsr);
        m_prev = idx;
    endtask

    // One round: press_at / wrong_at are SHOW-cycle offsets, -1 for none
    task automatic play_round(input int hold, input int press_at, input int wrong_at, input bit last);
        int idx;
        int span;
        int wbit;
        bit hit;
        logic [N_HOLES-1:0] b;
        bus.i_hold_len = HOLD_W'(hold);
        wait_pick(idx);
`ifdef SPEEDUP_EN
        span = m_hold;
`else
        span = hold;
`endif
        if (span < 1) span = 1;
        wbit = (idx + 1 + int'($urandom_range(0, N_HOLES - 2))) % N_HOLES;
        hit  = 1'b0;
        for (int j = 0; (j < span) && !hit; j++) begin
            b = '0;
            if (j == press_at) b = b | (N_HOLES'(1) << idx);
            if (j == wrong_at) b = b | (N_HOLES'(1) << wbit);
            bus.button = b;
            tick();
            if (j == press_at) begin
                hit     = 1'b1;
                m_score = sat1(m_score);
`ifdef SPEEDUP_EN
                m_hold = m_hold - (m_hold / 8);
                if (m_hold < MIN_HOLD) m_hold = MIN_HOLD;
`endif
            end else begin
                if (j == wrong_at) m_miss = sat1(m_miss);
                if (j == span - 1) m_miss = sat1(m_miss);
            end
            if (hit || (j == span - 1)) begin
                chk("end_mole", 32'(bus.o_mole), 0);
                chk("hit_pulse", 32'(bus.o_hit), 32'(hit));
            end else begin
                chk("show_mole", 32'(bus.o_mole), 32'(1) << idx);
                chk("no_hit", 32'(bus.o_hit), 0);
            end
            chk("score", 32'(bus.o_score), m_score);
            chk("miss", 32'(bus.o_miss), m_miss);
        end
        bus.button = '0;
        for (int g = 0; g < GAP_CYCLES; g++) begin
            chk("gap_dark", 32'(bus.o_mole), 0);
            chk("gap_busy", 32'(bus.o_busy), 1);
            if (g > 0) chk("hit_once", 32'(bus.o_hit), 0);
            tick();
        end
        chk("round_done", 32'(bus.o_done), 32'(last));
        chk("round_busy", 32'(bus.o_busy), 32'(!last));
    endtask

    initial begin
        #200000;
        n_checks++;
        $display("FAIL watchdog: got no finish expected finish");
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        int idx;
        int h;
        int pa;
        int wa;
        bus.i_start     = 1'b0;
        bus.i_seed_dv   = 1'b0;
        bus.i_seed_data = '0;
        bus.i_hold_len  = '0;
        bus.button      = '0;
        m_prev          = -1;

        // Reset values
        #2 reset = 1'b0;
        tick();
        tick();
        chk("rst_mole", 32'(bus.o_mole), 0);
        chk("rst_score", 32'(bus.o_score), 0);
        chk("rst_miss", 32'(bus.o_miss), 0);
        chk("rst_hit", 32'(bus.o_hit), 0);
        chk("rst_busy", 32'(bus.o_busy), 0);
        chk("rst_done", 32'(bus.o_done), 0);
        chk("rst_rand", 32'(bus.o_rand), 1);
        @(negedge clk);
        reset = 1'b1;
        tick();

        // LFSR seed and stepping
        bus.i_seed_data = LFSR_W'(1);
        bus.i_seed_dv   = 1'b1;
        tick();
        bus.i_seed_dv = 1'b0;
        chk("seed_one", 32'(bus.o_rand), 1);
        repeat (5) tick();
        chk("lfsr_5step", 32'(bus.o_rand), 'h21);
        chk("lfsr_model", 32'(bus.o_rand), m_lfsr);
        bus.i_seed_data = '0;
        bus.i_seed_dv   = 1'b1;
        tick();
        bus.i_seed_dv = 1'b0;
        chk("seed_zero", 32'(bus.o_rand), 1);
        chk("idle_busy", 32'(bus.o_busy), 0);

        // Directed game: hit, wrong+timeout, simultaneous hit/wrong on last cycle, timeout
        start_game(20);
        play_round(20, 3, -1, 1'b0);
        chk("plan_hit_score", 32'(bus.o_score), 1);
        play_round(10, -1, 2, 1'b0);
        chk("plan_wrong_timeout_miss", 32'(bus.o_miss), 2);
        play_round(6, 5, 5, 1'b0);
        chk("plan_simul_score", 32'(bus.o_score), 2);
        chk("plan_simul_miss", 32'(bus.o_miss), 2);
        play_round(5, -1, -1, 1'b1);
        repeat (3) tick();
        chk("done_held", 32'(bus.o_done), 1);
        chk("done_score_held", 32'(bus.o_score), m_score);
        chk("done_miss_held", 32'(bus.o_miss), m_miss);
        chk("done_dark", 32'(bus.o_mole), 0);

        // All-timeout game restarted from DONE, including a zero hold length
        start_game(3);
        play_round(3, -1, -1, 1'b0);
        play_round(0, -1, -1, 1'b0);
        play_round(1, -1, -1, 1'b0);
        play_round(2, -1, -1, 1'b1);
        chk("timeout_game_miss", 32'(bus.o_miss), 4);
        chk("timeout_game_score", 32'(bus.o_score), 0);

        // Reset in the middle of SHOW
        start_game(20);
        play_round(20, 2, -1, 1'b0);
        bus.i_hold_len = HOLD_W'(20);
        wait_pick(idx);
        tick();
        tick();
        #2 reset = 1'b0;
        #1;
        chk("midrst_mole", 32'(bus.o_mole), 0);
        chk("midrst_busy", 32'(bus.o_busy), 0);
        chk("midrst_score", 32'(bus.o_score), 0);
        chk("midrst_miss", 32'(bus.o_miss), 0);
        chk("midrst_rand", 32'(bus.o_rand), 1);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        tick();
        chk("postrst_idle", 32'(bus.o_busy), 0);
        chk("postrst_rand", 32'(bus.o_rand), m_lfsr);

        // Random games
        for (int gi = 0; gi < 6; gi++) begin
            h = int'($urandom_range(0, 12));
            start_game(h);
            for (int r = 0; r < ROUNDS; r++) begin
                h  = int'($urandom_range(0, 12));
                pa = int'($urandom_range(0, 14)) - 1;
                wa = int'($urandom_range(0, 14)) - 1;
                play_round(h, pa, wa, r == ROUNDS - 1);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mole_sched.md
Name: mole_sched

Overview:
Parametrised whack-a-mole round engine built around a seedable Fibonacci LFSR.
- Picks a random hole out of N_HOLES and lights it (one-hot) for a programmable hold time.
- Scores button presses against the lit hole; counts misses and timeouts; runs a fixed number of rounds.
- Sits between the board button synchronisers and the LED/7-seg display drivers, generalising the fixed 6-bit/8-hole random generator.

Parameters:
- LFSR_W, 6, LFSR width in bits (>= clog2(N_HOLES)).
- TAPS, 6'b110000, feedback tap mask (default: x^6+x^5+1, maximal length).
- N_HOLES, 8, number of holes, buttons and LEDs.
- HOLD_W, 24, width of the hold timer and of i_hold_len.
- GAP_CYCLES, 4, cycles with all moles off between rounds (>= 1).
- ROUNDS, 32, rounds per game.
- SCORE_W, 6, width of the score and miss counters (saturating).
- MIN_HOLD, 16, hold-time floor; used only with SPEEDUP_EN.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous active-low reset.
- i_start  in  1  level; sampled in IDLE or DONE to begin a game.
- i_seed_dv  in  1  seed load strobe.
- i_seed_data  in  LFSR_W  seed value.
- i_hold_len  in  HOLD_W  mole visible time in cycles; sampled at each PICK.
- button  in  N_HOLES  player buttons, already synchronised to clk, active-high.
- o_mole  out  N_HOLES  one-hot lit hole; 0 when none.
- o_score  out  SCORE_W  hits this game.
- o_miss  out  SCORE_W  wrong presses plus timeouts this game.
- o_hit  out  1  one-cycle pulse on a correct hit.
- o_busy  out  1  high in PICK, SHOW and GAP.
- o_done  out  1  high in DONE.
- o_rand  out  LFSR_W  current LFSR state, for display and debug.

Behaviour:
- Reset (async assert, sync release):
  - LFSR = 1; state IDLE.
  - All outputs 0 except o_rand = 1.
  - Round counter, timers, previous-hole register and button edge register cleared.
- LFSR:
  - Steps every cycle in every state: fb = ^(lfsr & TAPS); next = {lfsr[LFSR_W-2:0], fb}.
  - i_seed_dv has priority over stepping; the next state is i_seed_data, and a zero seed loads 1.
  - The state never reaches 0.
- Press detect: press = button & ~button_q, where button_q is button registered one cycle.
- IDLE: o_mole = 0. When i_start = 1: clear score, miss and round; go to PICK.
- PICK:
  - idx = lfsr[clog2(N_HOLES)-1:0].
  - The candidate is valid if idx < N_HOLES and idx != previous hole. The first round has no previous hole.
  - If invalid, stay in PICK; the next LFSR value is tried next cycle.
  - If valid:
    - o_mole <= 1 << idx; previous hole <= idx.
    - timer <= max(i_hold_len, 1), or the current hold length under SPEEDUP_EN.
    - Go to SHOW.
- SHOW:
  - Correct hit (press & o_mole nonzero): o_hit pulse, score +1 (saturating), go to GAP. Any wrong press in the same cycle is ignored.
  - Wrong press (press nonzero, no correct bit): miss +1 (saturating), stay in SHOW, timer keeps running.
  - Timer decrements each cycle. When it reaches 0 with no hit that cycle: miss +1, go to GAP.
  - Hit and timeout in the same cycle: the hit wins.
- GAP:
  - o_mole = 0 for GAP_CYCLES cycles; then round +1.
  - If round == ROUNDS go to DONE, else go to PICK.
- DONE:
  - o_mole = 0; o_done = 1; score and miss held.
  - When i_start = 1: clear counters, go to PICK (a new game).
- Latency:
  - From i_start to first mole lit: at least 2 cycles.
  - From correct press edge to o_hit: 1 cycle after the edge is registered.
- Reset asserted mid-game forces IDLE immediately. Counters clear; the LFSR returns to 1.

Optional Feature:
Macro SPEEDUP_EN.
- Defined:
  - A hold register is loaded with i_hold_len on start.
  - On each hit, hold -= hold >> 3, clamped to no less than MIN_HOLD.
  - PICK uses this register instead of i_hold_len.
- Undefined: i_hold_len is used directly; MIN_HOLD is unused; no extra registers.

Decomposition:
- Package mole_pkg holds:
  - the state enum {IDLE, PICK, SHOW, GAP, DONE};
  - the default TAPS constant;
  - a clog2 helper function.
- Sub-module lfsr_core (params LFSR_W, TAPS; ports clk, reset, seed_dv, seed_data, q) isolates the generator so it can be reused and tested alone.
- The FSM, timers and counters stay in mole_sched.

Test Plan:
- LFSR: reset, then seed 6'h01 via i_seed_dv, 5 free cycles -> o_rand = 6'h21; seed 6'h00 -> o_rand = 6'h01 on the next cycle.
- Hit: i_hold_len = 20, start, press the lit button after 3 cycles -> o_hit pulses once; o_score = 1; o_mole = 0 for 4 cycles; new mole at a different index.
- Timeout and wrong press: hold 10, one press on an unlit hole, then no further press -> o_miss = 2 after the timeout; o_score = 0.
- Simultaneous events: correct and wrong button rising together on the final timer cycle -> score +1, miss unchanged.
- Full game: ROUNDS = 4 with all timeouts -> o_done = 1 and o_miss = 4; o_score and o_miss held; i_start restarts with both counters at 0.
- Reset mid-SHOW -> o_mole, o_busy and counters go to 0 asynchronously; o_rand = 1. With SPEEDUP_EN, hold 64 -> 56 -> 49 on successive hits, floored at MIN_HOLD.
